trace_capture_ctrl: RTL

Sequencer and port arbiter for the instruction trace buffer SRAM macro. It captures retired PC/instruction pairs into a circular buffer and handles arm, trigger and post-trigger countdown, then freezes capture. It shares the single-port SRAM between capture writes and MMIO-driven readback. It sits between the core commit stage, the telemetry MMIO adapter (trace status/index/data registers) and the trace SRAM.

---
 rtl/trace_pkg.sv | 28 ++
 rtl/trace_capture_ctrl_port_arb.sv | 98 +++++++++
 rtl/trace_capture_ctrl.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared types and constants for the instruction trace capture block.
// Entries are stored as {pc, instr}, with the PC in the upper half.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    localparam int TRACE_DEPTH_DEFAULT = 64;
    localparam int ENTRY_W             = 64;
    localparam int PC_W                = 32;
    localparam int INSTR_W             = 32;
    localparam int PC_LSB              = 32;
    localparam int INSTR_LSB           = 0;

    function automatic logic [ENTRY_W-1:0] pack_entry(input logic [PC_W-1:0]    pc,
                                                      input logic [INSTR_W-1:0] instr);
        logic [ENTRY_W-1:0] entry;
        entry                        = '0;
        entry[PC_LSB +: PC_W]        = pc;
        entry[INSTR_LSB +: INSTR_W]  = instr;
        return entry;
    endfunction

endpackage

// File: rtl/trace_capture_ctrl_port_arb.sv
// Single-port SRAM arbiter for the trace buffer: capture writes always win,
// readback requests wait in a one-deep slot, and returned data is held for MMIO.
module trace_port_arb
    import trace_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    input  logic               rd_req_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    input  logic [ENTRY_W-1:0] sram_rdata_i,
    output logic               sram_cs_o,
    output logic               sram_we_o,
    output logic [ADDR_W-1:0]  sram_addr_o,
    output logic [ENTRY_W-1:0] sram_wdata_o,
    output logic [PC_W-1:0]    rd_pc_o,
    output logic [INSTR_W-1:0] rd_instr_o,
    output logic               rd_valid_o
);

    logic               pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0]  pend_addr_q,  pend_addr_d;
    logic               cs_q,    cs_d;
    logic               we_q,    we_d;
    logic [ADDR_W-1:0]  addr_q,  addr_d;
    logic [ENTRY_W-1:0] wdata_q, wdata_d;
    logic               ret_q,   ret_d;
    logic [ENTRY_W-1:0] hold_q,  hold_d;

    logic               req_valid;
    logic [ADDR_W-1:0]  req_addr;
    logic [ENTRY_W-1:0] rd_entry;

    always_comb begin
        // A fresh request always supersedes whatever address is still waiting.
        req_valid    = rd_req_i || pend_valid_q;
        req_addr     = rd_req_i ? rd_addr_i : pend_addr_q;

        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        cs_d         = 1'b0;
        we_d         = 1'b0;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ret_d        = cs_q && !we_q;
        hold_d       = ret_q ? sram_rdata_i : hold_q;

        if (wr_en_i) begin
            cs_d         = 1'b1;
            we_d         = 1'b1;
            addr_d       = wr_addr_i;
            wdata_d      = wr_data_i;
            pend_valid_d = req_valid;
            pend_addr_d  = req_addr;
        end else if (req_valid) begin
            cs_d         = 1'b1;
            addr_d       = req_addr;
            pend_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            cs_q         <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            ret_q        <= 1'b0;
            hold_q       <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            cs_q         <= cs_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ret_q        <= ret_d;
            hold_q       <= hold_d;
        end
    end

    // Return data is forwarded in the cycle it arrives so data and valid coincide.
    assign rd_entry     = ret_q ? sram_rdata_i : hold_q;
    assign rd_pc_o      = rd_entry[PC_LSB +: PC_W];
    assign rd_instr_o   = rd_entry[INSTR_LSB +: INSTR_W];
    assign rd_valid_o   = ret_q;
    assign sram_cs_o    = cs_q;
    assign sram_we_o    = we_q;
    assign sram_addr_o  = addr_q;
    assign sram_wdata_o = wdata_q;

endmodule

// File: rtl/trace_capture_ctrl.sv
// Trace capture sequencer: arm/trigger/post-trigger countdown over a circular
// buffer of retired {pc, instr} pairs, sharing the SRAM port with readback.
module trace_capture_ctrl
    import trace_pkg::*;
#(
    parameter int TRACE_DEPTH    = TRACE_DEPTH_DEFAULT,
    parameter int TRACE_PTR_BITS = $clog2(TRACE_DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      commit_valid_i,
    input  logic [31:0]               commit_pc_i,
    input  logic [31:0]               commit_instr_i,
    input  logic                      cfg_arm_i,
    input  logic                      cfg_clear_i,
    input  logic                      sw_trigger_i,
    input  logic                      cfg_trig_pc_en_i,
    input  logic [31:0]               cfg_trig_pc_i,
    input  logic [TRACE_PTR_BITS-1:0] cfg_post_count_i,
    input  logic                      rd_req_i,
    input  logic [TRACE_PTR_BITS-1:0] rd_addr_i,
    output logic [31:0]               rd_pc_o,
    output logic [31:0]               rd_instr_o,
    output logic                      rd_valid_o,
    output logic                      sram_cs_o,
    output logic                      sram_we_o,
    output logic [TRACE_PTR_BITS-1:0] sram_addr_o,
    output logic [63:0]               sram_wdata_o,
    input  logic [63:0]               sram_rdata_i,
    output logic [1:0]                state_o,
    output logic                      triggered_o,
    output logic                      wrapped_o,
    output logic [TRACE_PTR_BITS-1:0] wr_ptr_o
);

    localparam logic [TRACE_PTR_BITS-1:0] PTR_ONE  = TRACE_PTR_BITS'(1);
    localparam logic [TRACE_PTR_BITS-1:0] PTR_LAST = TRACE_PTR_BITS'(TRACE_DEPTH - 1);

    trace_state_e              state_q,     state_d;
    logic [TRACE_PTR_BITS-1:0] wr_ptr_q,    wr_ptr_d;
    logic [TRACE_PTR_BITS-1:0] post_cnt_q,  post_cnt_d;
    logic                      triggered_q, triggered_d;
    logic                      wrapped_q,   wrapped_d;

    logic                      capture_en;
    logic                      pc_match;
    logic                      trig_hit;

    assign pc_match = cfg_trig_pc_en_i && commit_valid_i && (commit_pc_i == cfg_trig_pc_i);
    assign trig_hit = sw_trigger_i || pc_match;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        post_cnt_d  = post_cnt_q;
        triggered_d = triggered_q;
        wrapped_d   = wrapped_q;
        capture_en  = 1'b0;

        // Clear outranks arm; both drop any commit or trigger in the same cycle.
        if (cfg_clear_i) begin
            state_d     = ST_IDLE;
            wr_ptr_d    = '0;
            post_cnt_d  = '0;
            triggered_d = 1'b0;
            wrapped_d   = 1'b0;
        end else if (cfg_arm_i) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = '0;
            post_cnt_d  = '0;
            triggered_d = 1'b0;
            wrapped_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    capture_en = commit_valid_i;
                    if (trig_hit) begin
                        triggered_d = 1'b1;
                        post_cnt_d  = cfg_post_count_i;
                        state_d     = (cfg_post_count_i == '0) ? ST_DONE : ST_POST;
                    end
                end
                ST_POST: begin
                    if (commit_valid_i) begin
                        capture_en = 1'b1;
                        post_cnt_d = post_cnt_q - PTR_ONE;
                        if (post_cnt_q == PTR_ONE) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                default: begin
                end
            endcase

            if (capture_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                if (wr_ptr_q == PTR_LAST) begin
                    wrapped_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            post_cnt_q  <= '0;
            triggered_q <= 1'b0;
            wrapped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            post_cnt_q  <= post_cnt_d;
            triggered_q <= triggered_d;
            wrapped_q   <= wrapped_d;
        end
    end

    trace_port_arb #(
        .ADDR_W (TRACE_PTR_BITS)
    ) u_port_arb (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_en_i      (capture_en),
        .wr_addr_i    (wr_ptr_q),
        .wr_data_i    (pack_entry(commit_pc_i, commit_instr_i)),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .sram_rdata_i (sram_rdata_i),
        .sram_cs_o    (sram_cs_o),
        .sram_we_o    (sram_we_o),
        .sram_addr_o  (sram_addr_o),
        .sram_wdata_o (sram_wdata_o),
        .rd_pc_o      (rd_pc_o),
        .rd_instr_o   (rd_instr_o),
        .rd_valid_o   (rd_valid_o)
    );

    assign state_o     = state_q;
    assign triggered_o = triggered_q;
    assign wrapped_o   = wrapped_q;
    assign wr_ptr_o    = wr_ptr_q;

endmodule
